// File: rtl/adc_acq_ctrl.sv
// Acquisition controller for the ADC decimation chain: sequences chain reset,
// discards the start-up transient and buffers decimated samples in a FWFT FIFO.
//
// state  | meaning
// IDLE   | chain held in reset, FIFO readable, waiting for start
// FLUSH  | chain held in reset for FLUSH_CYCLES cycles
// SETTLE | chain running, output samples counted and discarded
// RUN    | chain running, output samples pushed into the FIFO
module adc_acq_ctrl #(
    parameter int DW           = 35,
    parameter int FIFO_DEPTH   = 8,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [7:0]    settle_len,
    output logic          chain_rstn,
    input  logic          chain_vld,
    input  logic [DW-1:0] chain_dat,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          busy,
    output logic          ovf,
    output logic [15:0]   sample_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLUSH  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    logic [1:0]    state_q,  state_d;
    logic [FW-1:0] flush_q,  flush_d;
    logic [7:0]    settle_q, settle_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic [15:0]   cnt_q,    cnt_d;
    logic          busy_q;
    logic          rstn_q;
    logic          valid_q;
    logic [DW-1:0] mem_q [FIFO_DEPTH];

    logic accept;
    logic pop;
    logic push_req;
    logic push_ok;

    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        settle_d = settle_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;

        accept   = (state_q == S_IDLE) && start && !stop;
        pop      = valid_q && m_ready;
        push_req = (state_q == S_RUN) && chain_vld;
        // A full FIFO still takes the push when the head leaves on the same edge.
        push_ok  = push_req && ((count_q != DEPTH_C) || pop);

        if (accept) begin
            state_d  = S_FLUSH;
            flush_d  = FLUSH_LOAD;
            settle_d = settle_len;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            cnt_d    = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            if (push_req && !push_ok) begin
                ovf_d = 1'b1;
            end
            if (push_ok && !pop) begin
                count_d = count_q + (AW + 1)'(1);
            end else if (pop && !push_ok) begin
                count_d = count_q - (AW + 1)'(1);
            end

            if (stop && (state_q != S_IDLE)) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_FLUSH: begin
                        if (flush_q == '0) begin
                            state_d = (settle_q == 8'd0) ? S_RUN : S_SETTLE;
                        end else begin
                            flush_d = flush_q - FW'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (chain_vld) begin
                            settle_d = settle_q - 8'd1;
                            if (settle_q == 8'd1) begin
                                state_d = S_RUN;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            flush_q  <= '0;
            settle_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rstn_q   <= 1'b0;
            valid_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            settle_q <= settle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d != S_IDLE);
            rstn_q   <= (state_d == S_SETTLE) || (state_d == S_RUN);
            valid_q  <= (count_d != '0);
            if (push_ok) begin
                mem_q[wr_ptr_q] <= chain_dat;
            end
        end
    end

    assign chain_rstn = rstn_q;
    assign busy       = busy_q;
    assign ovf        = ovf_q;
    assign sample_cnt = cnt_q;
    assign m_valid    = valid_q;
    assign m_data     = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Directed and randomized bench for adc_acq_ctrl against a queue-based
// transaction model of the acquisition sequence.
module tb_adc_acq_ctrl;

    localparam int DW    = 35;
    localparam int DEPTH = 8;
    localparam int FLUSH = 16;

    localparam int P_IDLE   = 0;
    localparam int P_FLUSH  = 1;
    localparam int P_SETTLE = 2;
    localparam int P_RUN    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [7:0]    settle_len;
    logic          chain_rstn;
    logic          chain_vld;
    logic [DW-1:0] chain_dat;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          ovf;
    logic [15:0]   sample_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model
    int            ph;
    int            flush_left;
    int            settle_left;
    logic [DW-1:0] q [$];
    bit            m_ovf;
    int            m_cnt;
    logic [DW-1:0] last_dat;

    always #5 clk = ~clk;

    adc_acq_ctrl #(
        .DW(DW),
        .FIFO_DEPTH(DEPTH),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .settle_len(settle_len),
        .chain_rstn(chain_rstn),
        .chain_vld(chain_vld),
        .chain_dat(chain_dat),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .busy(busy),
        .ovf(ovf),
        .sample_cnt(sample_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit do_pop;
        bit do_push;
        if (rst) begin
            ph    = P_IDLE;
            q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            do_pop  = (q.size() > 0) && m_ready;
            do_push = (ph == P_RUN) && chain_vld;
            if (ph == P_IDLE && start && !stop) begin
                q.delete();
                m_ovf       = 1'b0;
                m_cnt       = 0;
                ph          = P_FLUSH;
                flush_left  = FLUSH;
                settle_left = int'(settle_len);
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    if (q.size() < DEPTH) begin
                        q.push_back(chain_dat);
                        if (m_cnt < 65535) m_cnt++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (stop && ph != P_IDLE) begin
                    ph = P_IDLE;
                end else if (ph == P_FLUSH) begin
                    flush_left--;
                    if (flush_left == 0) ph = (settle_left == 0) ? P_RUN : P_SETTLE;
                end else if (ph == P_SETTLE && chain_vld) begin
                    settle_left--;
                    if (settle_left == 0) ph = P_RUN;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("busy", 64'(busy), 64'(ph != P_IDLE));
        chk("chain_rstn", 64'(chain_rstn), 64'(ph == P_SETTLE || ph == P_RUN));
        chk("m_valid", 64'(m_valid), 64'(q.size() > 0));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
        if (q.size() > 0) chk("m_data", 64'(m_data), 64'(q[0]));
    endtask

    task automatic cyc(input bit s, input bit p, input bit v, input bit r);
        logic [63:0] rr;
        rr        = {$urandom, $urandom};
        start     = s;
        stop      = p;
        chain_vld = v;
        m_ready   = r;
        chain_dat = rr[DW-1:0];
        last_dat  = chain_dat;
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    initial begin
        int low;
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        settle_len = 8'd0;
        chain_vld  = 1'b0;
        chain_dat  = '0;
        m_ready    = 1'b0;
        ph         = P_IDLE;
        m_ovf      = 1'b0;
        m_cnt      = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("reset_m_data", 64'(m_data), 64'd0);
        rst = 1'b0;
        cyc(0, 0, 0, 0);

        // settle_len=3: flush length, three discards, fourth sample buffered
        settle_len = 8'd3;
        cyc(1, 0, 0, 0);
        low = (chain_rstn === 1'b0) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            if (chain_rstn !== 1'b0) break;
            cyc(0, 0, 0, 0);
            if (chain_rstn === 1'b0) low++;
        end
        chk("flush_len", 64'(low), 64'(FLUSH));
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 0);
        end
        chk("settle_discard", 64'(m_valid), 64'd0);
        cyc(0, 0, 1, 0);
        chk("fourth_valid", 64'(m_valid), 64'd1);
        chk("fourth_data", 64'(m_data), 64'(last_dat));
        chk("fourth_cnt", 64'(sample_cnt), 64'd1);
        cyc(0, 1, 0, 1);

        // settle_len=0: straight to RUN after flush
        settle_len = 8'd0;
        cyc(1, 0, 0, 0);
        repeat (FLUSH) cyc(0, 0, 0, 0);
        chk("direct_run_rstn", 64'(chain_rstn), 64'd1);
        cyc(0, 0, 1, 0);
        chk("direct_run_data", 64'(m_data), 64'(last_dat));
        cyc(0, 1, 0, 0);

        // overflow: 10 strobes into an 8-deep FIFO, then drain, then start clears ovf
        cyc(1, 0, 0, 0);
        repeat (FLUSH) cyc(0, 0, 0, 0);
        repeat (10) cyc(0, 0, 1, 0);
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("ovf_cnt", 64'(sample_cnt), 64'd8);
        repeat (8) cyc(0, 0, 0, 1);
        chk("drained", 64'(m_valid), 64'd0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("ovf_cleared", 64'(ovf), 64'd0);

        // full FIFO with simultaneous push and pop
        repeat (FLUSH) cyc(0, 0, 0, 0);
        repeat (8) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        chk("full_pushpop_ovf", 64'(ovf), 64'd0);
        chk("full_pushpop_cnt", 64'(sample_cnt), 64'd9);
        cyc(0, 1, 0, 1);
        repeat (7) cyc(0, 0, 0, 1);
        chk("full_drained", 64'(m_valid), 64'd0);

        // stop during SETTLE (strobe with stop is discarded)
        settle_len = 8'd5;
        cyc(1, 0, 0, 0);
        repeat (FLUSH) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        chk("settle_stop_rstn", 64'(chain_rstn), 64'd0);
        chk("settle_stop_valid", 64'(m_valid), 64'd0);

        // stop in RUN with a coincident strobe; 3 samples readable in IDLE
        settle_len = 8'd0;
        cyc(1, 0, 0, 0);
        repeat (FLUSH) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        chk("run_stop_busy", 64'(busy), 64'd0);
        chk("run_stop_cnt", 64'(sample_cnt), 64'd3);
        repeat (3) cyc(0, 0, 0, 1);
        chk("run_stop_drained", 64'(m_valid), 64'd0);

        // rst during RUN with 5 buffered
        cyc(1, 0, 0, 0);
        repeat (FLUSH) cyc(0, 0, 0, 0);
        repeat (5) cyc(0, 0, 1, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        chk("rst_run_valid", 64'(m_valid), 64'd0);
        chk("rst_run_cnt", 64'(sample_cnt), 64'd0);
        chk("rst_run_busy", 64'(busy), 64'd0);
        chk("rst_run_data", 64'(m_data), 64'd0);

        // start and stop together in IDLE
        cyc(1, 1, 0, 0);
        chk("start_stop_busy", 64'(busy), 64'd0);
        cyc(0, 0, 0, 0);
        chk("start_stop_rstn", 64'(chain_rstn), 64'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            settle_len = 8'($urandom_range(0, 4));
            rst = ($urandom_range(0, 299) == 0);
            cyc($urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
